// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: two-port round-robin arbiter in front of DataMemory
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pN_req/we/addr/wdata      request from port N (held until granted)
//   pN_gnt                    combinational grant, accepted on edge with req && gnt
//   pN_resp_valid/rdata/err   registered one-cycle response for port N
//   mem_addr/write_enable/write_data/read_data  DataMemory port (combinational read)
module data_memory_arbiter #(
    parameter int SIZE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_resp_valid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    output logic        p1_resp_valid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic [31:0] mem_addr,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    localparam logic [31:0] SIZE_W = 32'(SIZE);
    logic        last_grant;
    logic        sel;
    logic        any_gnt;
    logic        g_we;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic        bad;
    logic [31:0] rdata_n;
    // Under contention the port that did not win last time gets the grant.
    assign p0_gnt  = p0_req && (!p1_req || last_grant);
    assign p1_gnt  = p1_req && (!p0_req || !last_grant);
    assign sel     = p1_gnt;
    assign any_gnt = p0_gnt || p1_gnt;
    assign g_we    = sel ? p1_we    : p0_we;
    assign g_addr  = sel ? p1_addr  : p0_addr;
    assign g_wdata = sel ? p1_wdata : p0_wdata;
    // Word index compared at full width so huge addresses never alias into range.
    assign bad     = (g_addr[1:0] != 2'b00) || ({2'b00, g_addr[31:2]} >= SIZE_W);
    assign mem_addr         = any_gnt ? g_addr : '0;
    assign mem_write_data   = any_gnt ? g_wdata : '0;
    assign mem_write_enable = any_gnt && g_we && !bad;
    assign rdata_n = (!g_we && !bad) ? mem_read_data : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant    <= 1'b1;
            p0_resp_valid <= 1'b0;
            p0_rdata      <= '0;
            p0_err        <= 1'b0;
            p1_resp_valid <= 1'b0;
            p1_rdata      <= '0;
            p1_err        <= 1'b0;
        end else begin
            last_grant    <= any_gnt ? sel : last_grant;
            p0_resp_valid <= p0_gnt;
            p1_resp_valid <= p1_gnt;
            if (p0_gnt) begin
                p0_rdata <= rdata_n;
                p0_err   <= bad;
            end
            if (p1_gnt) begin
                p1_rdata <= rdata_n;
                p1_err   <= bad;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed vector bench for data_memory_arbiter with a DataMemory model
module tb_data_memory_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p1_gnt, p0_resp_valid, p1_resp_valid, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_write_enable;
    logic [31:0] mem [16];
    logic [31:0] rnd [16];
    int checks = 0;
    int errors = 0;

    data_memory_arbiter #(.SIZE(16)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_resp_valid(p0_resp_valid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_resp_valid(p1_resp_valid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write_enable) mem[mem_addr[5:2]] <= mem_write_data;
    assign mem_read_data = mem[mem_addr[5:2]];

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, mwe;
        logic        v0;
        logic [31:0] rd0;
        logic        e0;
        logic        v1;
        logic [31:0] rd1;
        logic        e1;
    } vec_t;
    vec_t v [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                         input logic r1, w1, input logic [31:0] a1, d1);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    endtask

    initial begin
        // r0 w0 a0 d0 | r1 w1 a1 d1 | g0 g1 mwe | v0 rd0 e0 | v1 rd1 e1 (resp of previous row)
        v[0]  = '{'1,'1,32'h8,32'hDEADBEEF, '0,'0,32'h0,32'h0,       '1,'0,'1, '0,32'h0,'0,        '0,32'h0,'0};
        v[1]  = '{'0,'0,32'h0,32'h0,        '1,'0,32'h8,32'h0,       '0,'1,'0, '1,32'h0,'0,        '0,32'h0,'0};
        v[2]  = '{'0,'0,32'h0,32'h0,        '0,'0,32'h0,32'h0,       '0,'0,'0, '0,32'h0,'0,        '1,32'hDEADBEEF,'0};
        v[3]  = '{'1,'1,32'h0,32'h11111111, '0,'0,32'h0,32'h0,       '1,'0,'1, '0,32'h0,'0,        '0,32'hDEADBEEF,'0};
        v[4]  = '{'0,'0,32'h0,32'h0,        '1,'1,32'h4,32'h22222222,'0,'1,'1, '1,32'h0,'0,        '0,32'hDEADBEEF,'0};
        v[5]  = '{'1,'0,32'h0,32'h0,        '1,'0,32'h4,32'h0,       '1,'0,'0, '0,32'h0,'0,        '1,32'h0,'0};
        v[6]  = '{'1,'0,32'h0,32'h0,        '1,'0,32'h4,32'h0,       '0,'1,'0, '1,32'h11111111,'0, '0,32'h0,'0};
        v[7]  = '{'1,'0,32'h0,32'h0,        '1,'0,32'h4,32'h0,       '1,'0,'0, '0,32'h11111111,'0, '1,32'h22222222,'0};
        v[8]  = '{'1,'0,32'h0,32'h0,        '1,'0,32'h4,32'h0,       '0,'1,'0, '1,32'h11111111,'0, '0,32'h22222222,'0};
        v[9]  = '{'0,'0,32'h0,32'h0,        '0,'0,32'h0,32'h0,       '0,'0,'0, '0,32'h11111111,'0, '1,32'h22222222,'0};
        v[10] = '{'1,'1,32'h6,32'h99999999, '0,'0,32'h0,32'h0,       '1,'0,'0, '0,32'h11111111,'0, '0,32'h22222222,'0};
        v[11] = '{'1,'0,32'h40,32'h0,       '0,'0,32'h0,32'h0,       '1,'0,'0, '1,32'h0,'1,        '0,32'h22222222,'0};
        v[12] = '{'1,'0,32'h4,32'h0,        '0,'0,32'h0,32'h0,       '1,'0,'0, '1,32'h0,'1,        '0,32'h22222222,'0};
        v[13] = '{'0,'0,32'h0,32'h0,        '1,'0,32'h0,32'h0,       '0,'1,'0, '1,32'h22222222,'0, '0,32'h22222222,'0};
        v[14] = '{'1,'0,32'h44,32'h0,       '1,'0,32'h8,32'h0,       '1,'0,'0, '0,32'h22222222,'0, '1,32'h11111111,'0};
        v[15] = '{'1,'0,32'h44,32'h0,       '1,'0,32'h8,32'h0,       '0,'1,'0, '1,32'h0,'1,        '0,32'h11111111,'0};
        v[16] = '{'0,'0,32'h0,32'h0,        '0,'0,32'h0,32'h0,       '0,'0,'0, '0,32'h0,'1,        '1,32'hDEADBEEF,'0};
        v[17] = '{'1,'1,32'hC,32'h5A5A5A5A, '0,'0,32'h0,32'h0,       '1,'0,'1, '0,32'h0,'1,        '0,32'hDEADBEEF,'0};
        v[18] = '{'0,'0,32'h0,32'h0,        '1,'0,32'hC,32'h0,       '0,'1,'0, '1,32'h0,'0,        '0,32'hDEADBEEF,'0};
        v[19] = '{'0,'0,32'h0,32'h0,        '0,'0,32'h0,32'h0,       '0,'0,'0, '0,32'h0,'0,        '1,32'h5A5A5A5A,'0};
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;

        #12;
        chk("reset_v0", 32'(p0_resp_valid), 32'h0);
        chk("reset_v1", 32'(p1_resp_valid), 32'h0);
        chk("reset_rd0", p0_rdata, 32'h0);
        chk("reset_rd1", p1_rdata, 32'h0);
        chk("reset_e0", 32'(p0_err), 32'h0);
        chk("reset_e1", 32'(p1_err), 32'h0);
        chk("reset_mwe", 32'(mem_write_enable), 32'h0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(v[i].r0, v[i].w0, v[i].a0, v[i].d0, v[i].r1, v[i].w1, v[i].a1, v[i].d1);
            #1;
            chk($sformatf("vec%0d_g0", i), 32'(p0_gnt), 32'(v[i].g0));
            chk($sformatf("vec%0d_g1", i), 32'(p1_gnt), 32'(v[i].g1));
            chk($sformatf("vec%0d_mwe", i), 32'(mem_write_enable), 32'(v[i].mwe));
            chk($sformatf("vec%0d_v0", i), 32'(p0_resp_valid), 32'(v[i].v0));
            chk($sformatf("vec%0d_rd0", i), p0_rdata, v[i].rd0);
            chk($sformatf("vec%0d_e0", i), 32'(p0_err), 32'(v[i].e0));
            chk($sformatf("vec%0d_v1", i), 32'(p1_resp_valid), 32'(v[i].v1));
            chk($sformatf("vec%0d_rd1", i), p1_rdata, v[i].rd1);
            chk($sformatf("vec%0d_e1", i), 32'(p1_err), 32'(v[i].e1));
            if (!v[i].g0 && !v[i].g1) chk($sformatf("vec%0d_idle_addr", i), mem_addr, 32'h0);
        end

        // p1 alone: 16 back-to-back writes, then 16 back-to-back reads
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i <= 16; i++) begin
                @(negedge clk);
                if (i < 16) drive('0, '0, 32'h0, 32'h0, '1, pass == 0, 32'(4 * i), rnd[i]);
                else drive('0, '0, 32'h0, 32'h0, '0, '0, 32'h0, 32'h0);
                #1;
                if (i < 16) chk($sformatf("b2b%0d_%0d_g1", pass, i), 32'(p1_gnt), 32'h1);
                if (i < 16) chk($sformatf("b2b%0d_%0d_mwe", pass, i), 32'(mem_write_enable), 32'(pass == 0));
                if (i > 0) begin
                    chk($sformatf("b2b%0d_%0d_v1", pass, i), 32'(p1_resp_valid), 32'h1);
                    chk($sformatf("b2b%0d_%0d_e1", pass, i), 32'(p1_err), 32'h0);
                    chk($sformatf("b2b%0d_%0d_rd1", pass, i), p1_rdata, pass == 0 ? 32'h0 : rnd[i-1]);
                end
            end
        end

        // asynchronous reset while a response is being presented
        @(negedge clk);
        drive('1, '0, 32'h8, 32'h0, '0, '0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        chk("pre_rst_v0", 32'(p0_resp_valid), 32'h1);
        chk("pre_rst_rd0", p0_rdata, rnd[2]);
        rst = 1'b1;
        #1;
        chk("rst_v0", 32'(p0_resp_valid), 32'h0);
        chk("rst_rd0", p0_rdata, 32'h0);
        chk("rst_e0", 32'(p0_err), 32'h0);
        chk("rst_v1", 32'(p1_resp_valid), 32'h0);
        chk("rst_rd1", p1_rdata, 32'h0);
        chk("rst_e1", 32'(p1_err), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_req_ignored", 32'(p0_resp_valid), 32'h0);
        @(negedge clk);
        drive('0, '0, 32'h0, 32'h0, '0, '0, 32'h0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        drive('1, '0, 32'h8, 32'h0, '1, '0, 32'hC, 32'h0);
        #1;
        chk("post_rst_g0", 32'(p0_gnt), 32'h1);
        chk("post_rst_g1", 32'(p1_gnt), 32'h0);
        @(negedge clk);
        drive('0, '0, 32'h0, 32'h0, '1, '0, 32'hC, 32'h0);
        #1;
        chk("post_rst_v0", 32'(p0_resp_valid), 32'h1);
        chk("post_rst_rd0", p0_rdata, rnd[2]);
        chk("post_rst_g1b", 32'(p1_gnt), 32'h1);
        @(negedge clk);
        drive('0, '0, 32'h0, 32'h0, '0, '0, 32'h0, 32'h0);
        #1;
        chk("post_rst_v1", 32'(p1_resp_valid), 32'h1);
        chk("post_rst_rd1", p1_rdata, rnd[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
